// File: rtl/activation_cache.sv
// Dilated causal tap buffer feeding a conv1d layer: caches 8-channel activation
// history in a circular buffer and presents four taps spaced DILATION steps apart.
module activation_cache #(
  parameter int W        = 16,
  parameter int DILATION = 1,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in_d0,
  input  logic signed [W-1:0] in_d1,
  input  logic signed [W-1:0] in_d2,
  input  logic signed [W-1:0] in_d3,
  input  logic signed [W-1:0] in_d4,
  input  logic signed [W-1:0] in_d5,
  input  logic signed [W-1:0] in_d6,
  input  logic signed [W-1:0] in_d7,
  input  logic                in_v,
  output logic signed [W-1:0] a0_d0,
  output logic signed [W-1:0] a0_d1,
  output logic signed [W-1:0] a0_d2,
  output logic signed [W-1:0] a0_d3,
  output logic signed [W-1:0] a0_d4,
  output logic signed [W-1:0] a0_d5,
  output logic signed [W-1:0] a0_d6,
  output logic signed [W-1:0] a0_d7,
  output logic signed [W-1:0] a1_d0,
  output logic signed [W-1:0] a1_d1,
  output logic signed [W-1:0] a1_d2,
  output logic signed [W-1:0] a1_d3,
  output logic signed [W-1:0] a1_d4,
  output logic signed [W-1:0] a1_d5,
  output logic signed [W-1:0] a1_d6,
  output logic signed [W-1:0] a1_d7,
  output logic signed [W-1:0] a2_d0,
  output logic signed [W-1:0] a2_d1,
  output logic signed [W-1:0] a2_d2,
  output logic signed [W-1:0] a2_d3,
  output logic signed [W-1:0] a2_d4,
  output logic signed [W-1:0] a2_d5,
  output logic signed [W-1:0] a2_d6,
  output logic signed [W-1:0] a2_d7,
  output logic signed [W-1:0] a3_d0,
  output logic signed [W-1:0] a3_d1,
  output logic signed [W-1:0] a3_d2,
  output logic signed [W-1:0] a3_d3,
  output logic signed [W-1:0] a3_d4,
  output logic signed [W-1:0] a3_d5,
  output logic signed [W-1:0] a3_d6,
  output logic signed [W-1:0] a3_d7,
  output logic                out_v,
  output logic                busy,
  output logic                overrun
);

  localparam int AW   = $clog2(DEPTH);
  localparam int FMAX = 3 * DILATION;
  localparam int FW   = $clog2(FMAX + 1);

  localparam logic [AW-1:0] OFS1 = AW'(DILATION);
  localparam logic [AW-1:0] OFS2 = AW'(2 * DILATION);
  localparam logic [AW-1:0] OFS3 = AW'(3 * DILATION);
  localparam logic [FW-1:0] FIL1 = FW'(DILATION);
  localparam logic [FW-1:0] FIL2 = FW'(2 * DILATION);
  localparam logic [FW-1:0] FIL3 = FW'(3 * DILATION);

  typedef enum logic [2:0] {
    IDLE,
    RD2,
    RD1,
    RD0,
    OUT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   base;
  logic [AW-1:0]   raddr_q;
  logic [AW-1:0]   raddr_d;
  logic [FW-1:0]   fill;
  logic [8*W-1:0]  in_vec;
  logic [8*W-1:0]  rdata;
  logic [8*W-1:0]  mem [DEPTH];
  logic [8*W-1:0]  a0_q;
  logic [8*W-1:0]  a1_q;
  logic [8*W-1:0]  a2_q;
  logic [8*W-1:0]  a3_q;
  logic            accept;

  assign in_vec = {in_d7, in_d6, in_d5, in_d4, in_d3, in_d2, in_d1, in_d0};
  assign busy   = (state_q != IDLE);
  assign accept = rst && (state_q == IDLE) && in_v;

  // Registered read address plus registered data: each tap lands two cycles after its read is issued
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= in_vec;
    end
    rdata <= mem[raddr_q];
  end

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    case (state_q)
      IDLE: begin
        if (in_v) begin
          state_d = RD2;
          raddr_d = wptr - OFS1;
        end
      end
      RD2: begin
        state_d = RD1;
        raddr_d = base - OFS2;
      end
      RD1: begin
        state_d = RD0;
        raddr_d = base - OFS3;
      end
      RD0:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Taps older than the recorded history read as zero, so stale memory never leaks out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr    <= '0;
      base    <= '0;
      raddr_q <= '0;
      fill    <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      out_v   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      out_v   <= (state_q == OUT);
      if (in_v && busy) begin
        overrun <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (in_v) begin
            a3_q <= in_vec;
            base <= wptr;
            wptr <= wptr + 1'b1;
          end
        end
        RD1: a2_q <= (fill < FIL1) ? '0 : rdata;
        RD0: a1_q <= (fill < FIL2) ? '0 : rdata;
        OUT: begin
          a0_q <= (fill < FIL3) ? '0 : rdata;
          if (fill != FIL3) begin
            fill <= fill + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign a0_d0 = a0_q[0*W +: W];
  assign a0_d1 = a0_q[1*W +: W];
  assign a0_d2 = a0_q[2*W +: W];
  assign a0_d3 = a0_q[3*W +: W];
  assign a0_d4 = a0_q[4*W +: W];
  assign a0_d5 = a0_q[5*W +: W];
  assign a0_d6 = a0_q[6*W +: W];
  assign a0_d7 = a0_q[7*W +: W];
  assign a1_d0 = a1_q[0*W +: W];
  assign a1_d1 = a1_q[1*W +: W];
  assign a1_d2 = a1_q[2*W +: W];
  assign a1_d3 = a1_q[3*W +: W];
  assign a1_d4 = a1_q[4*W +: W];
  assign a1_d5 = a1_q[5*W +: W];
  assign a1_d6 = a1_q[6*W +: W];
  assign a1_d7 = a1_q[7*W +: W];
  assign a2_d0 = a2_q[0*W +: W];
  assign a2_d1 = a2_q[1*W +: W];
  assign a2_d2 = a2_q[2*W +: W];
  assign a2_d3 = a2_q[3*W +: W];
  assign a2_d4 = a2_q[4*W +: W];
  assign a2_d5 = a2_q[5*W +: W];
  assign a2_d6 = a2_q[6*W +: W];
  assign a2_d7 = a2_q[7*W +: W];
  assign a3_d0 = a3_q[0*W +: W];
  assign a3_d1 = a3_q[1*W +: W];
  assign a3_d2 = a3_q[2*W +: W];
  assign a3_d3 = a3_q[3*W +: W];
  assign a3_d4 = a3_q[4*W +: W];
  assign a3_d5 = a3_q[5*W +: W];
  assign a3_d6 = a3_q[6*W +: W];
  assign a3_d7 = a3_q[7*W +: W];

endmodule

// File: tb/tb_activation_cache.sv
// Directed bench for activation_cache: one instance at D=2/DEPTH=8, one at D=1/DEPTH=4,
// sharing clock, reset and input data.
module tb_activation_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_d [8];
  logic        in_v2 = 1'b0;
  logic        in_v1 = 1'b0;
  logic [15:0] t2 [4][8];
  logic [15:0] t1 [4][8];
  logic        out_v2, busy2, ovr2;
  logic        out_v1, busy1, ovr1;
  int          passed = 0;
  int          total = 0;
  int          lat;
  int          busy_cnt;
  int          pulses;

  always #5 clk = ~clk;

  activation_cache #(.W(16), .DILATION(2), .DEPTH(8)) u_d2 (
    .clk(clk), .rst(rst), .in_v(in_v2),
    .in_d0(in_d[0]), .in_d1(in_d[1]), .in_d2(in_d[2]), .in_d3(in_d[3]),
    .in_d4(in_d[4]), .in_d5(in_d[5]), .in_d6(in_d[6]), .in_d7(in_d[7]),
    .a0_d0(t2[0][0]), .a0_d1(t2[0][1]), .a0_d2(t2[0][2]), .a0_d3(t2[0][3]),
    .a0_d4(t2[0][4]), .a0_d5(t2[0][5]), .a0_d6(t2[0][6]), .a0_d7(t2[0][7]),
    .a1_d0(t2[1][0]), .a1_d1(t2[1][1]), .a1_d2(t2[1][2]), .a1_d3(t2[1][3]),
    .a1_d4(t2[1][4]), .a1_d5(t2[1][5]), .a1_d6(t2[1][6]), .a1_d7(t2[1][7]),
    .a2_d0(t2[2][0]), .a2_d1(t2[2][1]), .a2_d2(t2[2][2]), .a2_d3(t2[2][3]),
    .a2_d4(t2[2][4]), .a2_d5(t2[2][5]), .a2_d6(t2[2][6]), .a2_d7(t2[2][7]),
    .a3_d0(t2[3][0]), .a3_d1(t2[3][1]), .a3_d2(t2[3][2]), .a3_d3(t2[3][3]),
    .a3_d4(t2[3][4]), .a3_d5(t2[3][5]), .a3_d6(t2[3][6]), .a3_d7(t2[3][7]),
    .out_v(out_v2), .busy(busy2), .overrun(ovr2)
  );

  activation_cache #(.W(16), .DILATION(1), .DEPTH(4)) u_d1 (
    .clk(clk), .rst(rst), .in_v(in_v1),
    .in_d0(in_d[0]), .in_d1(in_d[1]), .in_d2(in_d[2]), .in_d3(in_d[3]),
    .in_d4(in_d[4]), .in_d5(in_d[5]), .in_d6(in_d[6]), .in_d7(in_d[7]),
    .a0_d0(t1[0][0]), .a0_d1(t1[0][1]), .a0_d2(t1[0][2]), .a0_d3(t1[0][3]),
    .a0_d4(t1[0][4]), .a0_d5(t1[0][5]), .a0_d6(t1[0][6]), .a0_d7(t1[0][7]),
    .a1_d0(t1[1][0]), .a1_d1(t1[1][1]), .a1_d2(t1[1][2]), .a1_d3(t1[1][3]),
    .a1_d4(t1[1][4]), .a1_d5(t1[1][5]), .a1_d6(t1[1][6]), .a1_d7(t1[1][7]),
    .a2_d0(t1[2][0]), .a2_d1(t1[2][1]), .a2_d2(t1[2][2]), .a2_d3(t1[2][3]),
    .a2_d4(t1[2][4]), .a2_d5(t1[2][5]), .a2_d6(t1[2][6]), .a2_d7(t1[2][7]),
    .a3_d0(t1[3][0]), .a3_d1(t1[3][1]), .a3_d2(t1[3][2]), .a3_d3(t1[3][3]),
    .a3_d4(t1[3][4]), .a3_d5(t1[3][5]), .a3_d6(t1[3][6]), .a3_d7(t1[3][7]),
    .out_v(out_v1), .busy(busy1), .overrun(ovr1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] obsTap(input int sel, input int m, input int c);
    return (sel == 2) ? t2[m][c] : t1[m][c];
  endfunction

  // Expected channel c of tap m is base_m + c when that tap has history, else zero
  task automatic checkTaps(input int sel, input string tag, input logic [15:0] b0,
                           input logic [15:0] b1, input logic [15:0] b2,
                           input logic [15:0] b3, input logic [3:0] vm);
    logic [15:0] b [4];
    logic [15:0] e;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int m = 0; m < 4; m++) begin
      for (int c = 0; c < 8; c++) begin
        e = vm[m] ? (b[m] + 16'(c)) : 16'h0000;
        checkOutput($sformatf("%s_a%0d_d%0d", tag, m, c), 32'(obsTap(sel, m, c)), 32'(e));
      end
    end
  endtask

  // Drives one vector (base_val + channel) and waits, bounded, for the output pulse
  task automatic applyStimulus(input int sel, input logic [15:0] base_val);
    @(negedge clk);
    for (int c = 0; c < 8; c++) in_d[c] = base_val + 16'(c);
    if (sel == 2) in_v2 = 1'b1;
    else in_v1 = 1'b1;
    @(posedge clk);
    #1;
    in_v2 = 1'b0;
    in_v1 = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!((sel == 2) ? out_v2 : out_v1) && lat < 12) begin
      if ((sel == 2) ? busy2 : busy1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic histSample(input int t);
    logic [3:0] vm;
    applyStimulus(2, 16'(t * 16));
    checkOutput($sformatf("hist%0d_latency", t), 32'(lat), 32'd4);
    vm = {1'b1, t >= 2, t >= 4, t >= 6};
    checkTaps(2, $sformatf("hist%0d", t), 16'((t - 6) * 16), 16'((t - 4) * 16),
              16'((t - 2) * 16), 16'(t * 16), vm);
  endtask

  initial begin
    for (int c = 0; c < 8; c++) in_d[c] = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_v", 32'(out_v2), 32'd0);
    checkOutput("rst_busy", 32'(busy2), 32'd0);
    checkOutput("rst_overrun", 32'(ovr2), 32'd0);
    checkOutput("rst_out_v_d1", 32'(out_v1), 32'd0);
    checkTaps(2, "rst", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;

    // Single vector after reset
    applyStimulus(2, 16'h0010);
    checkOutput("single_latency", 32'(lat), 32'd4);
    checkOutput("single_busy_cycles", 32'(busy_cnt), 32'd4);
    checkTaps(2, "single", 16'h0, 16'h0, 16'h0, 16'h0010, 4'b1000);
    @(posedge clk);
    #1;
    checkOutput("single_pulse_width", 32'(out_v2), 32'd0);
    checkOutput("single_busy_after", 32'(busy2), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("single_hold_a3_d5", 32'(t2[3][5]), 32'h0015);

    // History fill and wrap-around at D=2, DEPTH=8
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 20; t++) histSample(t);

    // Overrun on the D=1 instance: second strobe two cycles after the first
    @(negedge clk);
    for (int c = 0; c < 8; c++) in_d[c] = 16'h0100 + 16'(c);
    in_v1 = 1'b1;
    @(posedge clk);
    #1;
    in_v1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ovr_before", 32'(ovr1), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 8; c++) in_d[c] = 16'h0200 + 16'(c);
    in_v1 = 1'b1;
    @(posedge clk);
    #1;
    in_v1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ovr_set", 32'(ovr1), 32'd1);
    checkOutput("ovr_no_early_pulse", 32'(out_v1), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ovr_first_pulse", 32'(out_v1), 32'd1);
    checkTaps(1, "ovr_first", 16'h0, 16'h0, 16'h0, 16'h0100, 4'b1000);
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_v1) pulses++;
    end
    checkOutput("ovr_single_pulse", 32'(pulses), 32'd0);
    applyStimulus(1, 16'h0300);
    checkOutput("ovr_next_latency", 32'(lat), 32'd4);
    checkTaps(1, "ovr_next", 16'h0, 16'h0, 16'h0100, 16'h0300, 4'b1100);
    checkOutput("ovr_sticky", 32'(ovr1), 32'd1);

    // Reset in the middle of a sequence on the D=2 instance
    @(negedge clk);
    for (int c = 0; c < 8; c++) in_d[c] = 16'h0400 + 16'(c);
    in_v2 = 1'b1;
    @(posedge clk);
    #1;
    in_v2 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_out_v", 32'(out_v2), 32'd0);
    checkOutput("midrst_busy", 32'(busy2), 32'd0);
    checkOutput("midrst_overrun_d1", 32'(ovr1), 32'd0);
    checkTaps(2, "midrst", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_v2) pulses++;
    end
    checkOutput("midrst_no_pulse", 32'(pulses), 32'd0);
    applyStimulus(2, 16'h0500);
    checkOutput("midrst_next_latency", 32'(lat), 32'd4);
    checkTaps(2, "midrst_next", 16'h0, 16'h0, 16'h0, 16'h0500, 4'b1000);

    // Negative data through the D=1 instance, read back as every tap position
    applyStimulus(1, 16'h8000);
    checkTaps(1, "neg0", 16'h0, 16'h0, 16'h0, 16'h8000, 4'b1000);
    applyStimulus(1, 16'h7ff0);
    checkTaps(1, "neg1", 16'h0, 16'h0, 16'h8000, 16'h7ff0, 4'b1100);
    applyStimulus(1, 16'hfff0);
    checkTaps(1, "neg2", 16'h0, 16'h8000, 16'h7ff0, 16'hfff0, 4'b1110);
    applyStimulus(1, 16'h0000);
    checkOutput("neg3_latency", 32'(lat), 32'd4);
    checkTaps(1, "neg3", 16'h8000, 16'h7ff0, 16'hfff0, 16'h0000, 4'b1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/activation_cache.md
# activation_cache

Dilated causal tap buffer that sits between two conv1d layers. It accepts one 8-channel activation vector per time step and stores the history in a circular buffer. For each accepted vector it presents the four kernel taps a0..a3 (oldest to newest, spaced DILATION steps apart) in the exact port shape the downstream conv1d consumes. It is the writer and reader for that layer's cached history, and its output strobe marks when the taps are valid.

## Interface
- W, 16: signed element width.
- DILATION, 1: time-step spacing between adjacent taps (≥1).
- DEPTH, 4: circular buffer entries, power of two, must be ≥ 3*DILATION+1.
- clk  in  1  clock; everything on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_d0..in_d7  in  W each, signed  new activation vector (channels 0..7).
- in_v  in  1  single-cycle strobe; the vector is valid in this cycle.
- a0_d0..a0_d7, a1_d0..a1_d7, a2_d0..a2_d7, a3_d0..a3_d7  out  W each, signed  taps for time t-3D, t-2D, t-D and t.
- out_v  out  1  one-cycle pulse; all 32 tap outputs are valid and stay held until the next pulse.
- busy  out  1  high whenever the FSM is not IDLE.
- overrun  out  1  sticky; set when in_v arrives while busy.

## Operation
- Storage: DEPTH x 8W memory with a synchronous 1-cycle read. One write port and one read port.
- Pointer: wptr has log2(DEPTH) bits and wraps modulo DEPTH. Tap addresses are (wptr_at_accept − m*DILATION) mod DEPTH for m = 1..3, computed as unsigned wrap-around subtraction.
- Fill counter: fill saturates at 3*DILATION. It holds the number of vectors written before the current one. Tap m is forced to zero when fill < m*DILATION, which gives causal zero padding. Stale memory contents are never exposed.
- FSM states: IDLE, RD2, RD1, RD0, OUT.
  - IDLE, in_v=1:
    - write the vector to mem[wptr];
    - a3 ← in_d*;
    - issue read of address wptr−D;
    - latch base=wptr;
    - wptr ← wptr+1;
    - go to RD2.
  - RD2: issue read base−2D, go to RD1.
  - RD1:
    - a2 ← rdata, or 0 if masked;
    - issue read base−3D;
    - go to RD0.
  - RD0: a1 ← rdata, or 0 if masked; go to OUT.
  - OUT:
    - a0 ← rdata, or 0 if masked;
    - out_v ← 1 for one cycle;
    - fill ← min(fill+1, 3D);
    - go to IDLE.
- Tap registers (a0..a3) update only inside this sequence. Between pulses they hold their values.
- in_v with busy=1: the vector is dropped and nothing is written. overrun ← 1 and stays set until reset.
- in_v in the same cycle that OUT completes: dropped, because busy is still 1.
- Arithmetic: none. Data passes through unchanged, sign preserved.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, wptr=0, fill=0;
  - out_v=0, busy=0, overrun=0;
  - all tap outputs = 0;
  - memory is not cleared.
- Latency: in_v sampled at edge n, then out_v is high for the one cycle following edge n+4.
- busy is high from edge n+1 through edge n+4 inclusive.
- Minimum accepted in_v spacing: 5 cycles.
- Reset mid-sequence: out_v is never pulsed for the aborted vector. That vector's memory write persists but is masked, because fill=0.
- rst deassertion is synchronised outside this block. The first accepted edge is the first edge with rst=1.

## Test plan
- Reset then single vector: D=2, DEPTH=8, in_d_c=0x0010+c. Required response:
  - out_v 4 cycles later;
  - a3_dc=0x0010+c;
  - a2, a1, a0 all 0;
  - busy high for 4 cycles.
- History fill: D=2, send samples t=0..6 with value t*16+c, 5-cycle spacing. Required taps per sample:
  - t=2: a2=sample 0, a1=a0=0;
  - t=4: a1=sample 0, a0=0;
  - t=6: a3=0x006c, a2=0x004c, a1=0x002c, a0=0x000c for channel c.
- Wrap-around: D=2, DEPTH=8, samples t=0..19. At t=19, a2/a1/a0 must equal samples 17/15/13. Every output from t≥6 onward is checked.
- Overrun: send in_v at n and n+2.
  - Only one out_v, carrying the first vector.
  - overrun=1 from n+3 and stays set.
  - The next accepted sample shows the first vector as a2 when D=1, never the dropped one.
- Reset mid-operation: assert rst=0 at n+2 after in_v at n.
  - No out_v.
  - All outputs read 0.
  - The next sample returns a0..a2=0.
- Negative data: in_d_c=0x8000|c with apply_relu irrelevant. Taps reproduce the values bit-exact, sign intact, across a later readout at D=1.
